ob_cmd_deser: RTL and testbench
===============================

Name: ob_cmd_deser

Overview:
Ingress deserialiser directly upstream of the order-book top level. Accepts a byte-serial framed command stream, assembles frames MSB-first into ob_pkg::cmd_t, and validates length and opcode. Issues each good command as a one-cycle cmd_vld_r/cmd_r push into the order book's ingress queue, gated by cmd_full_r. Malformed frames are dropped and counted.

Parameters:
CMD_BYTES, ($bits(ob_pkg::cmd_t)+7)/8, bytes per well-formed frame; must be >= 2.
CNT_W, 16, width of the saturating frame and error counters.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous assert, active-low, synchronous deassert is system-provided
in_vld  input  1  byte beat valid
in_sop  input  1  first byte of frame
in_eop  input  1  last byte of frame
in_data  input  8  frame byte, MSB-first
in_rdy  output  1  beat accepted when in_vld & in_rdy
cmd_full_r  input  1  order-book ingress queue full (registered)
cmd_vld_r  output  1  one-cycle push strobe to order book
cmd_r  output  $bits(ob_pkg::cmd_t)  command; valid when cmd_vld_r
frame_cnt_r  output  CNT_W  good commands issued, saturating
err_cnt_r  output  CNT_W  frames/beats dropped, saturating

Behaviour:
- Reset (rst low, async): state IDLE; cmd_vld_r=0, cmd_r=0, in_rdy=0, frame_cnt_r=0, err_cnt_r=0, byte count=0, shift register=0.
- in_rdy is registered: 1 in IDLE/COLLECT/DISCARD, 0 in PEND and during reset.
- Shift register: CMD_BYTES*8 bits, shift left 8 per accepted byte. cmd = low $bits(cmd_t) bits; pad bits are ignored.
- States: IDLE, COLLECT, DISCARD, PEND.
- IDLE: beat with sop loads byte, count=1, goes to COLLECT. Beat without sop gives err+1; eop stays IDLE, otherwise DISCARD.
- COLLECT: each beat increments count.
  - sop mid-frame: err+1; frame restarts with this byte, count=1.
  - eop with count==CMD_BYTES after increment: frame complete.
  - eop with count!=CMD_BYTES: err+1, IDLE.
  - Non-eop beat reaching count==CMD_BYTES+1: err+1, DISCARD.
- DISCARD: drops beats until an eop beat, then IDLE. A sop beat without eop restarts COLLECT and raises no extra error. A sop beat that also has eop goes to IDLE.
- Frame complete:
  - If the opcode field is not a legal ob_pkg::opcode_t value: err+1, IDLE.
  - Otherwise, if cmd_full_r=0 in that cycle: cmd_r loaded, cmd_vld_r=1 next cycle, frame+1, IDLE.
  - Otherwise: PEND, with the command held.
- PEND: in_rdy=0. On the first cycle with cmd_full_r=0, cmd_vld_r=1 next cycle, frame+1, IDLE.
- Latency: eop beat at cycle N gives cmd_vld_r at N+1 when not full. The next frame's sop is accepted at N+1.
- cmd_vld_r is never high more than one cycle per command and never issues in a cycle after cmd_full_r was sampled 1.
- cmd_r holds its last value when cmd_vld_r=0.
- Counters saturate at all-ones; they never wrap.
- Reset mid-frame or in PEND discards the partial or pending command; it is not counted.

Decomposition:
- ob_pkg: add opcode legality function is_legal_opc(opcode_t) and frame-format constants (CMD_BYTES default formula).
- cfg_pkg: CNT_W default.
- Sub-module: ob_sat_cnt (width-parameterised saturating incrementer), instantiated twice.
- FSM and shift register stay inline.

Test Plan:
1. Good frame with cmd_full_r=0: CMD_BYTES beats, valid opcode, uid=0x12 -> cmd_vld_r one cycle at eop+1, cmd_r.uid=0x12, frame_cnt_r=1, err_cnt_r=0.
2. Backpressure: same frame with cmd_full_r=1 for 5 cycles after eop -> in_rdy=0 during those cycles; cmd_vld_r one cycle after full drops; no beat lost from a following frame presented back-to-back.
3. Short frame (eop at CMD_BYTES-1) then long frame (CMD_BYTES+2 beats) -> no cmd_vld_r, err_cnt_r=2, next good frame issues normally.
4. Illegal opcode with correct length -> no cmd_vld_r, err_cnt_r=1. Orphan beat without sop in IDLE -> err_cnt_r=2, stays in DISCARD until eop.
5. sop mid-frame after 2 bytes, then a full good frame starting at that sop -> err_cnt_r=1, one command issued with the second frame's contents.
6. Assert rst low in PEND and mid-COLLECT -> outputs zero immediately (async). After release, first good frame issues with frame_cnt_r=1. Force counters to near saturation (CNT_W=2): 4 errors give err_cnt_r=3.

Source files
------------

// File: rtl/cfg_pkg.sv
// System-level defaults for the order-book ingress path.
package cfg_pkg;

  localparam int CNT_W_DFLT = 16;

endpackage

// File: rtl/ob_pkg.sv
// Order-book command format shared by the ingress deserialiser and its consumers.
// Also holds the opcode legality check and the frame-size constant.
package ob_pkg;

  typedef enum logic [2:0] {
    OPC_NEW    = 3'd1,
    OPC_CANCEL = 3'd2,
    OPC_MODIFY = 3'd3
  } opcode_t;

  // Packed MSB-first: the opcode is the first field on the wire after any pad bits.
  typedef struct packed {
    opcode_t     opc;
    logic        side;
    logic [7:0]  uid;
    logic [15:0] price;
    logic [8:0]  qty;
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2,
    ST_PEND    = 2'd3
  } des_state_t;

  localparam int CMD_W          = $bits(cmd_t);
  localparam int OPC_W          = $bits(opcode_t);
  localparam int CMD_BYTES_DFLT = (CMD_W + 7) / 8;

  function automatic logic is_legal_opc(input opcode_t opc);
    case (opc)
      OPC_NEW, OPC_CANCEL, OPC_MODIFY: return 1'b1;
      default:                         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ob_sat_cnt.sv
// Width-parameterised event counter that sticks at all-ones instead of wrapping.
module ob_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/ob_cmd_deser.sv
// Byte-serial framed command deserialiser feeding the order-book ingress queue.
// Frames are assembled MSB-first, checked for length and opcode, then pushed once.
module ob_cmd_deser
  import ob_pkg::*;
#(
  parameter int CMD_BYTES = ob_pkg::CMD_BYTES_DFLT,
  parameter int CNT_W     = cfg_pkg::CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in_sop,
  input  logic             in_eop,
  input  logic [7:0]       in_data,
  output logic             in_rdy,
  input  logic             cmd_full_r,
  output logic             cmd_vld_r,
  output cmd_t             cmd_r,
  output logic [CNT_W-1:0] frame_cnt_r,
  output logic [CNT_W-1:0] err_cnt_r,
  output des_state_t       o_dbg_state
);

  localparam int SH_W = CMD_BYTES * 8;
  localparam int BC_W = $clog2(CMD_BYTES + 2);
  localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(CMD_BYTES);
  localparam logic [BC_W-1:0] BC_OVER = BC_W'(CMD_BYTES + 1);

  des_state_t      r_state, w_state_nxt;
  logic [SH_W-1:0] r_shift, w_shift_nxt, w_shift_beat, w_shift_load;
  logic [BC_W-1:0] r_bcnt, w_bcnt_nxt, w_bcnt_inc;
  logic            r_in_rdy, r_cmd_vld;
  cmd_t            r_cmd, w_asm_cmd, w_pend_cmd, w_issue_cmd;
  logic            w_acc, w_err_inc, w_issue;
  logic [7:0]      w_unused_pad;

  // Handshake: a beat transfers on a cycle where in_vld and in_rdy are both high;
  // in_rdy is a register, so it never depends combinationally on in_vld.
  assign w_acc        = in_vld & r_in_rdy;
  assign w_bcnt_inc   = r_bcnt + BC_ONE;
  assign w_shift_beat = {r_shift[SH_W-9:0], in_data};
  assign w_shift_load = {{(SH_W-8){1'b0}}, in_data};
  assign w_asm_cmd    = cmd_t'(w_shift_beat[CMD_W-1:0]);
  assign w_pend_cmd   = cmd_t'(r_shift[CMD_W-1:0]);
  assign w_unused_pad = r_shift[SH_W-1 -: 8];

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bcnt_nxt  = r_bcnt;
    w_err_inc   = 1'b0;
    w_issue     = 1'b0;
    w_issue_cmd = w_pend_cmd;
    case (r_state)
      ST_IDLE: begin
        if (w_acc) begin
          if (in_sop && !in_eop) begin
            w_shift_nxt = w_shift_load;
            w_bcnt_nxt  = BC_ONE;
            w_state_nxt = ST_COLLECT;
          end else begin
            // Orphan beat, or a one-byte frame that can never be long enough.
            w_err_inc   = 1'b1;
            w_state_nxt = in_eop ? ST_IDLE : ST_DISCARD;
          end
        end
      end
      ST_COLLECT: begin
        if (w_acc) begin
          if (in_sop) begin
            w_err_inc = 1'b1;
            if (in_eop) begin
              w_state_nxt = ST_IDLE;
            end else begin
              w_shift_nxt = w_shift_load;
              w_bcnt_nxt  = BC_ONE;
            end
          end else begin
            w_shift_nxt = w_shift_beat;
            w_bcnt_nxt  = w_bcnt_inc;
            if (in_eop) begin
              w_state_nxt = ST_IDLE;
              if (w_bcnt_inc != BC_FULL || !is_legal_opc(w_asm_cmd.opc)) begin
                w_err_inc = 1'b1;
              end else if (!cmd_full_r) begin
                w_issue     = 1'b1;
                w_issue_cmd = w_asm_cmd;
              end else begin
                w_state_nxt = ST_PEND;
              end
            end else if (w_bcnt_inc == BC_OVER) begin
              w_err_inc   = 1'b1;
              w_state_nxt = ST_DISCARD;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (w_acc) begin
          if (in_eop) begin
            w_state_nxt = ST_IDLE;
          end else if (in_sop) begin
            w_shift_nxt = w_shift_load;
            w_bcnt_nxt  = BC_ONE;
            w_state_nxt = ST_COLLECT;
          end
        end
      end
      ST_PEND: begin
        if (!cmd_full_r) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_in_rdy  <= 1'b0;
      r_cmd_vld <= 1'b0;
      r_cmd     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bcnt    <= w_bcnt_nxt;
      r_in_rdy  <= (w_state_nxt != ST_PEND);
      r_cmd_vld <= w_issue;
      if (w_issue) begin
        r_cmd <= w_issue_cmd;
      end
    end
  end

  ob_sat_cnt #(.W(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_issue),
    .o_cnt (frame_cnt_r)
  );

  ob_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_err_inc),
    .o_cnt (err_cnt_r)
  );

  assign in_rdy      = r_in_rdy;
  assign cmd_vld_r   = r_cmd_vld;
  assign cmd_r       = r_cmd;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ob_cmd_deser.sv
// Scoreboard bench for ob_cmd_deser: frame-level stimulus with a reference model of
// expected commands and error counts; a second instance with 2-bit counters checks saturation.
module tb_ob_cmd_deser;
  import ob_pkg::*;

  localparam int NB   = CMD_BYTES_DFLT;
  localparam int FR_W = NB * 8;
  localparam int CW   = 16;
  localparam int QW   = CW + CMD_W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_vld = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          cmd_full_r = 1'b0;
  logic          in_rdy, cmd_vld_r, s_in_rdy, s_cmd_vld_r;
  cmd_t          cmd_r, s_cmd_r;
  logic [CW-1:0] frame_cnt_r, err_cnt_r;
  logic [1:0]    s_frame_cnt, s_err_cnt;
  des_state_t    dbg_state, s_dbg_state;

  int            total = 0, bad = 0;
  int            m_frames = 0, m_errs = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] mon_e;
  int            full_mode = 0;
  logic          gap_en = 1'b0;
  logic          full_s = 1'b0;
  logic          vld_prev = 1'b0;

  ob_cmd_deser dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_rdy(in_rdy), .cmd_full_r(cmd_full_r), .cmd_vld_r(cmd_vld_r),
    .cmd_r(cmd_r), .frame_cnt_r(frame_cnt_r), .err_cnt_r(err_cnt_r), .o_dbg_state(dbg_state)
  );

  ob_cmd_deser #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_sop(in_sop), .in_eop(in_eop),
    .in_data(in_data), .in_rdy(s_in_rdy), .cmd_full_r(cmd_full_r), .cmd_vld_r(s_cmd_vld_r),
    .cmd_r(s_cmd_r), .frame_cnt_r(s_frame_cnt), .err_cnt_r(s_err_cnt), .o_dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // 0 = not full, 1 = full, 2 = random
  initial forever begin
    @(posedge clk);
    #2;
    case (full_mode)
      0:       cmd_full_r = 1'b0;
      1:       cmd_full_r = 1'b1;
      default: cmd_full_r = ($urandom_range(0, 3) == 0);
    endcase
  end

  function automatic logic [FR_W-1:0] mk_frame(input bit legal);
    logic [63:0]      r;
    logic [FR_W-1:0]  f;
    logic [OPC_W-1:0] o;
    r = {$urandom(), $urandom()};
    f = r[FR_W-1:0];
    if (legal) begin
      o = OPC_W'($urandom_range(1, 3));
    end else begin
      o = OPC_W'($urandom_range(0, 4));
      if (o != 0) o = o + OPC_W'(3);
    end
    f[CMD_W-1 -: OPC_W] = o;
    return f;
  endfunction

  // ---------------- driver ----------------
  task automatic send_beat(input logic s, input logic e, input logic [7:0] d);
    int   t;
    logic ok;
    if (gap_en && $urandom_range(0, 3) == 0) begin
      in_vld = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    in_vld = 1'b1; in_sop = s; in_eop = e; in_data = d;
    t = 0; ok = 1'b0;
    while (!ok && t < 300) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_accept_timeout: in_rdy low for %0d cycles, required 1", t);
    end
    in_vld = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic send_seq(input logic [FR_W-1:0] f, input int n, input bit with_sop, input bit with_eop);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      if (i < NB) b = f[FR_W-1-8*i -: 8];
      else        b = 8'($urandom());
      send_beat(with_sop && (i == 0), with_eop && (i == n - 1), b);
    end
  endtask

  task automatic expect_good(input logic [FR_W-1:0] f);
    m_frames++;
    exp_q.push_back({CW'(sat(m_frames, CW)), f[CMD_W-1:0]});
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    m_frames = 0;
    m_errs   = 0;
    exp_q.delete();
  endtask

  task automatic check_counts(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    tick(2);
    check({tag, "_queue_drained"}, exp_q.size(), 0);
    check({tag, "_err_cnt"}, err_cnt_r, sat(m_errs, CW));
    check({tag, "_frame_cnt"}, frame_cnt_r, sat(m_frames, CW));
    check({tag, "_sat_err_cnt"}, s_err_cnt, sat(m_errs, 2));
    check({tag, "_sat_frame_cnt"}, s_frame_cnt, sat(m_frames, 2));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) full_s <= cmd_full_r;

  always @(negedge clk) begin
    if (rst && cmd_vld_r) begin
      check("vld_after_full", full_s, 0);
      check("vld_single_cycle", vld_prev, 0);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_cmd: got cmd 0x%0h, required no push", cmd_r);
      end else begin
        mon_e = exp_q.pop_front();
        check("cmd_r", cmd_r, mon_e[CMD_W-1:0]);
        check("frame_cnt_at_push", frame_cnt_r, mon_e[QW-1:CMD_W]);
        check("sat_cmd_vld", s_cmd_vld_r, 1);
        check("sat_cmd_r", s_cmd_r, mon_e[CMD_W-1:0]);
        check("sat_frame_cnt_at_push", s_frame_cnt, sat(int'(mon_e[QW-1:CMD_W]), 2));
      end
    end
    vld_prev = cmd_vld_r;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [FR_W-1:0] f, f2;
    cmd_t            c;
    int              kind, n;

    #12;
    check("rst_cmd_vld", cmd_vld_r, 0);
    check("rst_in_rdy", in_rdy, 0);
    check("rst_cmd_r", cmd_r, 0);
    check("rst_frame_cnt", frame_cnt_r, 0);
    check("rst_err_cnt", err_cnt_r, 0);
    check("rst_state", dbg_state, ST_IDLE);
    release_rst();
    check("post_rst_in_rdy", in_rdy, 1);

    // good frame, uid 0x12, push one cycle after eop
    f = mk_frame(1'b1);
    c = cmd_t'(f[CMD_W-1:0]);
    c.uid = 8'h12;
    f[CMD_W-1:0] = c;
    expect_good(f);
    send_seq(f, NB, 1'b1, 1'b1);
    check("t1_vld_at_eop_plus1", cmd_vld_r, 1);
    check("t1_uid", cmd_r.uid, 8'h12);
    tick(1);
    check("t1_vld_one_cycle", cmd_vld_r, 0);
    check_counts("t1");

    // backpressure, next frame presented back-to-back
    full_mode = 1;
    f  = mk_frame(1'b1);
    f2 = mk_frame(1'b1);
    expect_good(f);
    expect_good(f2);
    send_seq(f, NB, 1'b1, 1'b1);
    fork
      send_seq(f2, NB, 1'b1, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          check("t2_rdy_low_while_full", in_rdy, 0);
        end
        full_mode = 0;
      end
    join
    check_counts("t2");

    // short then long frame, then a good one
    send_seq(mk_frame(1'b1), NB - 1, 1'b1, 1'b1); m_errs++;
    send_seq(mk_frame(1'b1), NB + 2, 1'b1, 1'b1); m_errs++;
    f = mk_frame(1'b1);
    expect_good(f);
    send_seq(f, NB, 1'b1, 1'b1);
    check_counts("t3");

    // illegal opcode, then orphan beats held in DISCARD until eop
    send_seq(mk_frame(1'b0), NB, 1'b1, 1'b1); m_errs++;
    send_beat(1'b0, 1'b0, 8'($urandom())); m_errs++;
    check("t4_discard_1", dbg_state, ST_DISCARD);
    send_beat(1'b0, 1'b0, 8'($urandom()));
    check("t4_discard_2", dbg_state, ST_DISCARD);
    send_beat(1'b0, 1'b1, 8'($urandom()));
    check("t4_idle_after_eop", dbg_state, ST_IDLE);
    check_counts("t4");

    // sop mid-frame restarts with the new frame
    send_seq(mk_frame(1'b1), 2, 1'b1, 1'b0); m_errs++;
    f = mk_frame(1'b1);
    expect_good(f);
    send_seq(f, NB, 1'b1, 1'b1);
    check_counts("t5");

    // randomized mix with random backpressure and beat gaps
    gap_en = 1'b1;
    full_mode = 2;
    for (int it = 0; it < 200; it++) begin
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1, 2: begin
          f = mk_frame(1'b1);
          expect_good(f);
          send_seq(f, NB, 1'b1, 1'b1);
        end
        3: begin send_seq(mk_frame(1'b1), $urandom_range(2, NB - 1), 1'b1, 1'b1); m_errs++; end
        4: begin send_seq(mk_frame(1'b1), $urandom_range(NB + 1, NB + 3), 1'b1, 1'b1); m_errs++; end
        5: begin send_seq(mk_frame(1'b0), NB, 1'b1, 1'b1); m_errs++; end
        6: begin send_seq(mk_frame(1'b1), $urandom_range(1, 3), 1'b0, 1'b1); m_errs++; end
        default: begin
          n = $urandom_range(1, NB);
          send_seq(mk_frame(1'b1), n, ($urandom_range(0, 1) == 1), 1'b0);
          m_errs++;
          f = mk_frame(1'b1);
          expect_good(f);
          send_seq(f, NB, 1'b1, 1'b1);
        end
      endcase
      if (it % 50 == 49) check_counts("rand");
    end
    full_mode = 0;
    gap_en = 1'b0;
    check_counts("rand_end");

    // async reset while a command is pending
    full_mode = 1;
    send_seq(mk_frame(1'b1), NB, 1'b1, 1'b1);
    check("t6_pend_state", dbg_state, ST_PEND);
    check("t6_pend_rdy", in_rdy, 0);
    #2;
    rst = 1'b0;
    #1;
    check("t6_async_vld", cmd_vld_r, 0);
    check("t6_async_cmd_r", cmd_r, 0);
    check("t6_async_frame_cnt", frame_cnt_r, 0);
    check("t6_async_err_cnt", err_cnt_r, 0);
    check("t6_async_state", dbg_state, ST_IDLE);
    full_mode = 0;
    release_rst();

    // async reset mid-collect, then a fresh good frame counts from 1
    send_seq(mk_frame(1'b1), 2, 1'b1, 1'b0);
    check("t6_collect_state", dbg_state, ST_COLLECT);
    #2;
    rst = 1'b0;
    #1;
    check("t6_collect_rst_state", dbg_state, ST_IDLE);
    check("t6_collect_rst_rdy", in_rdy, 0);
    release_rst();
    f = mk_frame(1'b1);
    expect_good(f);
    send_seq(f, NB, 1'b1, 1'b1);
    check_counts("t6_post");

    // four errors: 2-bit counter sticks at 3
    repeat (4) begin
      send_beat(1'b0, 1'b1, 8'($urandom()));
      m_errs++;
    end
    check_counts("t6_sat");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
